// File: rtl/imem_loader.sv
// Program loader: accepts 32-bit instruction words over valid/ready and writes them
// big-endian, one byte per cycle, into the instruction memory while holding the CPU.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int MEM_BYTES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       word_in,
    input  logic              word_valid,
    input  logic              word_last,
    output logic              word_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-2:0] word_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    // Address of the final byte; checked on the byte just written so a full-size
    // memory (MEM_BYTES == 2**ADDR_W) never needs the pointer to hold MEM_BYTES.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       word_p0;
    logic              last_p0;
    logic [1:0]        lane_p0;
    logic              hs;

    assign hs = (state == S_WAIT) && word_valid && word_ready;

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    lane_byte = w[31:24];
            2'd1:    lane_byte = w[23:16];
            2'd2:    lane_byte = w[15:8];
            default: lane_byte = w[7:0];
        endcase
    endfunction

    // Stage p0: latched word and the lane currently presented on the write port
    always_ff @(posedge clk) begin
        if (hs) begin
            word_p0 <= word_in;
            last_p0 <= word_last;
            lane_p0 <= 2'd0;
        end else if (state == S_WRITE) begin
            lane_p0 <= lane_p0 + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            word_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr        <= '0;
                        word_count <= '0;
                        err        <= 1'b0;
                        word_ready <= 1'b1;
                        cpu_hold   <= 1'b1;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Byte 0 goes out on the handshake edge so lanes fill cycles H+1..H+4
                    if (hs) begin
                        word_ready <= 1'b0;
                        mem_we     <= 1'b1;
                        mem_addr   <= ptr;
                        mem_wdata  <= word_in[31:24];
                        ptr        <= ptr + 1'b1;
                        state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (lane_p0 != 2'd3) begin
                        mem_addr  <= ptr;
                        mem_wdata <= lane_byte(word_p0, 2'(lane_p0 + 2'd1));
                        ptr       <= ptr + 1'b1;
                    end else begin
                        mem_we     <= 1'b0;
                        word_count <= word_count + 1'b1;
                        if (last_p0) begin
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else if (mem_addr == LAST_ADDR) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            word_ready <= 1'b1;
                            state      <= S_WAIT;
                        end
                    end
                end
                default: begin
                    cpu_hold <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
